// File: rtl/maze_pkg.sv
// Shared types and constants for the maze pixel renderer.
package maze_pkg;

    localparam int unsigned CELL_LOG2 = 4;
    localparam int unsigned MAZE_LOG2 = 4;
    // Width/height of the maze area in pixels.
    localparam int unsigned MAZE_SPAN = 1 << (CELL_LOG2 + MAZE_LOG2);
    // First blanking line; the player position is sampled at column 0 of it.
    localparam int unsigned LATCH_ROW = 480;

    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        MapFloor = 2'b00,
        MapWall  = 2'b01,
        MapExit  = 2'b10,
        MapCoin  = 2'b11
    } map_code_t;

    localparam rgb_t DEF_BORDER_RGB  = 12'h333;
    localparam rgb_t DEF_FLOOR_RGB   = 12'h000;
    localparam rgb_t DEF_WALL_RGB    = 12'h00F;
    localparam rgb_t DEF_EXIT_RGB    = 12'h0F0;
    localparam rgb_t DEF_COIN_RGB    = 12'hFF0;
    localparam rgb_t TRANSPARENT_RGB = 12'h000;

endpackage

// File: rtl/mario_sprite_rom.sv
// 256x12 player sprite ROM, synchronous read with one cycle of latency.
// Address is {sub_y, sub_x}; 12'h000 marks a transparent pixel.
module mario_sprite_rom
    import maze_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*CELL_LOG2-1:0]   i_addr,
    output rgb_t                     o_data
);

    localparam rgb_t HAT_RGB      = 12'hF00;
    localparam rgb_t SKIN_RGB     = 12'hFA7;
    localparam rgb_t EYE_RGB      = 12'h111;
    localparam rgb_t OVERALLS_RGB = 12'h22F;

    rgb_t data_d, data_q;

    // Sprite art: columns 3..12, rows 1..14 opaque; hat, face with two eyes, overalls.
    function automatic rgb_t sprite_pixel(input logic [3:0] sy, input logic [3:0] sx);
        rgb_t px;
        if (sx < 4'd3 || sx > 4'd12 || sy == 4'd0 || sy == 4'd15) begin
            px = TRANSPARENT_RGB;
        end else if (sy <= 4'd4) begin
            px = HAT_RGB;
        end else if (sy <= 4'd9) begin
            px = (sy == 4'd6 && (sx == 4'd6 || sx == 4'd9)) ? EYE_RGB : SKIN_RGB;
        end else begin
            px = OVERALLS_RGB;
        end
        return px;
    endfunction

    // ROM lookup for the current address.
    always_comb begin
        data_d = sprite_pixel(i_addr[2*CELL_LOG2-1:CELL_LOG2], i_addr[CELL_LOG2-1:0]);
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/maze_pixel_renderer.sv
// Maze pixel renderer: 3-stage pipeline turning the VGA timing stream into RGB.
// S1 decodes position, S2 waits for map RAM / sprite ROM, S3 registers the colour mux.
module maze_pixel_renderer
    import maze_pkg::*;
#(
    parameter int unsigned MAZE_X0    = 192,
    parameter int unsigned MAZE_Y0    = 112,
    parameter rgb_t        BORDER_RGB = DEF_BORDER_RGB,
    parameter rgb_t        FLOOR_RGB  = DEF_FLOOR_RGB,
    parameter rgb_t        WALL_RGB   = DEF_WALL_RGB,
    parameter rgb_t        EXIT_RGB   = DEF_EXIT_RGB,
    parameter rgb_t        COIN_RGB   = DEF_COIN_RGB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_pix_valid,
    input  logic [9:0]               i_col,
    input  logic [9:0]               i_row,
    input  logic                     i_hsync,
    input  logic                     i_vsync,
    input  logic [MAZE_LOG2-1:0]     i_player_x,
    input  logic [MAZE_LOG2-1:0]     i_player_y,
    output logic [2*MAZE_LOG2-1:0]   o_map_addr,
    input  logic [1:0]               i_map_data,
    output logic [11:0]              o_rgb,
    output logic                     o_hsync,
    output logic                     o_vsync
);

    // Stage 1 registers
    logic                  s1_valid_d, s1_valid_q;
    logic                  s1_hs_d, s1_hs_q;
    logic                  s1_vs_d, s1_vs_q;
    logic                  s1_in_maze_d, s1_in_maze_q;
    logic [MAZE_LOG2-1:0]  s1_cell_x_d, s1_cell_x_q;
    logic [MAZE_LOG2-1:0]  s1_cell_y_d, s1_cell_y_q;
    logic [CELL_LOG2-1:0]  s1_sub_x_d, s1_sub_x_q;
    logic [CELL_LOG2-1:0]  s1_sub_y_d, s1_sub_y_q;

    // Player position latched once per frame
    logic [MAZE_LOG2-1:0]  player_x_d, player_x_q;
    logic [MAZE_LOG2-1:0]  player_y_d, player_y_q;

    // Stage 2 sideband registers
    logic                  s2_valid_d, s2_valid_q;
    logic                  s2_in_maze_d, s2_in_maze_q;
    logic                  s2_hs_d, s2_hs_q;
    logic                  s2_vs_d, s2_vs_q;
    logic                  s2_hit_d, s2_hit_q;

    // Stage 3 output registers
    rgb_t                  rgb_d, rgb_q;
    logic                  hsync_d, hsync_q;
    logic                  vsync_d, vsync_q;

    logic [9:0]            dx, dy;
    rgb_t                  sprite_rgb;

    mario_sprite_rom u_sprite_rom (
        .clk    (clk),
        .rst    (rst),
        .i_addr ({s1_sub_y_q, s1_sub_x_q}),
        .o_data (sprite_rgb)
    );

    assign o_map_addr = {s1_cell_y_q, s1_cell_x_q};

    // S1: offset into the maze; unsigned wrap makes left/above-maze pixels fail the range test.
    always_comb begin
        dx           = i_col - 10'(MAZE_X0);
        dy           = i_row - 10'(MAZE_Y0);
        s1_valid_d   = i_pix_valid;
        s1_hs_d      = i_hsync;
        s1_vs_d      = i_vsync;
        s1_in_maze_d = (dx < 10'(MAZE_SPAN)) && (dy < 10'(MAZE_SPAN));
        s1_cell_x_d  = dx[CELL_LOG2 +: MAZE_LOG2];
        s1_cell_y_d  = dy[CELL_LOG2 +: MAZE_LOG2];
        s1_sub_x_d   = dx[CELL_LOG2-1:0];
        s1_sub_y_d   = dy[CELL_LOG2-1:0];
    end

    // Player latch: only sampled at the start of vertical blanking to avoid tearing.
    always_comb begin
        player_x_d = player_x_q;
        player_y_d = player_y_q;
        if (i_row == 10'(LATCH_ROW) && i_col == 10'd0) begin
            player_x_d = i_player_x;
            player_y_d = i_player_y;
        end
    end

    // S2: carry sideband alongside the map RAM / sprite ROM read.
    always_comb begin
        s2_valid_d   = s1_valid_q;
        s2_in_maze_d = s1_in_maze_q;
        s2_hs_d      = s1_hs_q;
        s2_vs_d      = s1_vs_q;
        s2_hit_d     = (s1_cell_x_q == player_x_q) && (s1_cell_y_q == player_y_q);
    end

    // S3: colour priority mux; blanking forces black, syncs pass through.
    always_comb begin
        rgb_d   = '0;
        hsync_d = s2_hs_q;
        vsync_d = s2_vs_q;
        if (!s2_valid_q) begin
            rgb_d = '0;
        end else if (!s2_in_maze_q) begin
            rgb_d = BORDER_RGB;
        end else if (s2_hit_q && sprite_rgb != TRANSPARENT_RGB) begin
            rgb_d = sprite_rgb;
        end else begin
            unique case (map_code_t'(i_map_data))
                MapFloor: rgb_d = FLOOR_RGB;
                MapWall:  rgb_d = WALL_RGB;
                MapExit:  rgb_d = EXIT_RGB;
                MapCoin:  rgb_d = COIN_RGB;
                default:  rgb_d = FLOOR_RGB;
            endcase
        end
    end

    // Pipeline state; sync stages reset high so outputs are inactive during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_hs_q      <= 1'b1;
            s1_vs_q      <= 1'b1;
            s1_in_maze_q <= 1'b0;
            s1_cell_x_q  <= '0;
            s1_cell_y_q  <= '0;
            s1_sub_x_q   <= '0;
            s1_sub_y_q   <= '0;
            player_x_q   <= '0;
            player_y_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_in_maze_q <= 1'b0;
            s2_hs_q      <= 1'b1;
            s2_vs_q      <= 1'b1;
            s2_hit_q     <= 1'b0;
            rgb_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_hs_q      <= s1_hs_d;
            s1_vs_q      <= s1_vs_d;
            s1_in_maze_q <= s1_in_maze_d;
            s1_cell_x_q  <= s1_cell_x_d;
            s1_cell_y_q  <= s1_cell_y_d;
            s1_sub_x_q   <= s1_sub_x_d;
            s1_sub_y_q   <= s1_sub_y_d;
            player_x_q   <= player_x_d;
            player_y_q   <= player_y_d;
            s2_valid_q   <= s2_valid_d;
            s2_in_maze_q <= s2_in_maze_d;
            s2_hs_q      <= s2_hs_d;
            s2_vs_q      <= s2_vs_d;
            s2_hit_q     <= s2_hit_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
        end
    end

    assign o_rgb   = rgb_q;
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;

endmodule
